stopwatch_button_ctrl: RTL and testbench

Conditions the raw stop push-button of the stopwatch and produces the run/pause level and a clear request for the clock divider and counter stages. It synchronises and debounces the mechanical button. It toggles run/pause on a short press and issues a one-cycle clear pulse on a long press. It sits between the board button pin and the `clock_divider` stop input. It replaces the edge-triggered toggle flop currently clocked by the button itself.

---
 rtl/stopwatch_button_ctrl.sv | 123 ++++++++++++
 tb/tb_stopwatch_button_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_button_ctrl.sv
// ============================================================================
// Module   : stopwatch_button_ctrl
// Brief    : Synchronises and debounces the stop button, toggles run/pause on
//            a short press and issues a one-cycle clear pulse on a long press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_button_ctrl #(
    parameter int unsigned DB_CYCLES   = 1_000_000,
    parameter int unsigned LONG_CYCLES = 100_000_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic stop_n,
    output logic run,
    output logic clear_pulse,
    output logic stop_db
);

    localparam int unsigned c_DB_W   = $clog2(DB_CYCLES + 1);
    localparam int unsigned c_HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [c_DB_W-1:0]   c_DB_ZERO   = '0;
    localparam logic [c_DB_W-1:0]   c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ZERO = '0;
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYCLES - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX  = '1;

    localparam logic [1:0] c_ST_RELEASED  = 2'd0;
    localparam logic [1:0] c_ST_PRESSED   = 2'd1;
    localparam logic [1:0] c_ST_LONG_HELD = 2'd2;

    logic                r_sync1;
    logic                r_sync2;
    logic                r_stable;
    logic                r_stable_d;
    logic [c_DB_W-1:0]   r_db_cnt;
    logic [1:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_run;
    logic                r_clear_pulse;

    logic                w_fall;
    logic                w_rise;

    // Synchroniser and debouncer; any return to the accepted level restarts the count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_stable   <= 1'b1;
            r_stable_d <= 1'b1;
            r_db_cnt   <= c_DB_ZERO;
        end else begin
            r_sync1    <= stop_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= c_DB_ZERO;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_stable <= r_sync2;
                r_db_cnt <= c_DB_ZERO;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
        end
    end

    assign w_fall = r_stable_d & ~r_stable;
    assign w_rise = ~r_stable_d & r_stable;

    // Press classifier: the long-press threshold takes priority over a coincident release.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state       <= c_ST_RELEASED;
            r_hold_cnt    <= c_HOLD_ZERO;
            r_run         <= 1'b0;
            r_clear_pulse <= 1'b0;
        end else begin
            r_clear_pulse <= 1'b0;
            case (r_state)
                c_ST_RELEASED: begin
                    if (w_fall) begin
                        r_state    <= c_ST_PRESSED;
                        r_hold_cnt <= c_HOLD_ZERO;
                    end
                end
                c_ST_PRESSED: begin
                    if (r_hold_cnt != c_HOLD_MAX) begin
                        r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
                    end
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state       <= c_ST_LONG_HELD;
                        r_clear_pulse <= 1'b1;
                        r_run         <= 1'b0;
                    end else if (w_rise) begin
                        r_state <= c_ST_RELEASED;
                        r_run   <= ~r_run;
                    end
                end
                c_ST_LONG_HELD: begin
                    // Level test also catches a release that coincided with the threshold.
                    if (r_stable) begin
                        r_state <= c_ST_RELEASED;
                    end
                end
                default: begin
                    r_state <= c_ST_RELEASED;
                end
            endcase
        end
    end

    assign run         = r_run;
    assign clear_pulse = r_clear_pulse;
    assign stop_db     = r_stable;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_button_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_button_ctrl
// Brief    : Directed bench for stopwatch_button_ctrl (DB_CYCLES=4, LONG_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_button_ctrl;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;
    logic stop_n = 1'b1;
    logic run;
    logic clear_pulse;
    logic stop_db;

    int checks = 0;
    int errors = 0;

    stopwatch_button_ctrl #(
        .DB_CYCLES   (4),
        .LONG_CYCLES (16)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .stop_n      (stop_n),
        .run         (run),
        .clear_pulse (clear_pulse),
        .stop_db     (stop_db)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Press for 8 cycles then release; run must flip 7 cycles after release.
    task automatic short_press(input logic run_before);
        stop_n = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("sp_clear_hold", clear_pulse, 1'b0);
            chk("sp_run_hold", run, run_before);
            if (t == 5) chk("sp_db_before", stop_db, 1'b1);
            if (t == 6) chk("sp_db_fall", stop_db, 1'b0);
        end
        stop_n = 1'b1;
        for (int r = 1; r <= 7; r++) begin
            tick();
            chk("sp_clear_rel", clear_pulse, 1'b0);
            if (r == 5) chk("sp_db_still_low", stop_db, 1'b0);
            if (r == 6) begin
                chk("sp_db_rise", stop_db, 1'b1);
                chk("sp_run_before", run, run_before);
            end
            if (r == 7) chk("sp_run_toggle", run, ~run_before);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sp_run_settle", run, ~run_before);
        end
    endtask

    initial begin
        // Reset and idle
        reset  = 1'b1;
        stop_n = 1'b1;
        repeat (3) tick();
        chk("rst_run", run, 1'b0);
        chk("rst_clear", clear_pulse, 1'b0);
        chk("rst_db", stop_db, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_run", run, 1'b0);
            chk("idle_clear", clear_pulse, 1'b0);
            chk("idle_db", stop_db, 1'b1);
        end

        // Short presses: 0->1, 1->0, 0->1
        short_press(1'b0);
        short_press(1'b1);
        short_press(1'b0);

        // Bounce shorter than the debounce window is ignored
        for (int i = 0; i < 10; i++) begin
            stop_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) begin
                tick();
                chk("bnc_db", stop_db, 1'b1);
                chk("bnc_clear", clear_pulse, 1'b0);
                chk("bnc_run", run, 1'b1);
            end
        end
        stop_n = 1'b1;
        repeat (10) tick();
        chk("bnc_run_after", run, 1'b1);

        // Long press: PRESSED at tick 7, clear at tick 23
        stop_n = 1'b0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk("lp_clear", clear_pulse, (t == 23));
            chk("lp_run", run, (t < 23));
        end
        stop_n = 1'b1;
        for (int r = 1; r <= 12; r++) begin
            tick();
            chk("lp_rel_run", run, 1'b0);
            chk("lp_rel_clear", clear_pulse, 1'b0);
        end
        chk("lp_rel_db", stop_db, 1'b1);

        // Get run=1 so reset mid-hold visibly clears it
        short_press(1'b0);

        // Reset mid-hold: PRESSED at tick 7, hold_cnt=10 at tick 17, reset edge at 18
        stop_n = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            tick();
            chk("rh_run_pre", run, 1'b1);
            chk("rh_clear_pre", clear_pulse, 1'b0);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rh_run_rst", run, 1'b0);
        chk("rh_db_rst", stop_db, 1'b1);
        chk("rh_clear_rst", clear_pulse, 1'b0);
        // New PRESSED at tick 25 (reset edge + 7), clear at tick 41
        for (int t = 19; t <= 45; t++) begin
            tick();
            chk("rh_clear", clear_pulse, (t == 41));
            chk("rh_db", stop_db, (t < 24));
            chk("rh_run", run, 1'b0);
        end
        stop_n = 1'b1;
        repeat (10) tick();
        chk("rh_run_final", run, 1'b0);
        chk("rh_db_final", stop_db, 1'b1);

        // Button held through reset, released 10 cycles after deassertion
        stop_n = 1'b0;
        reset  = 1'b1;
        repeat (3) tick();
        chk("hr_db_rst", stop_db, 1'b1);
        reset = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 5) chk("hr_db_before", stop_db, 1'b1);
            if (t == 6) chk("hr_db_fall", stop_db, 1'b0);
            chk("hr_run_hold", run, 1'b0);
        end
        stop_n = 1'b1;
        for (int r = 1; r <= 7; r++) begin
            tick();
            chk("hr_clear", clear_pulse, 1'b0);
            if (r == 6) chk("hr_run_before", run, 1'b0);
            if (r == 7) chk("hr_run_toggle", run, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
